inta_sequencer: RTL and testbench

//  Interrupt-acknowledge sequencer for the 8259 PIC (8086 mode, two INTA pulses).

---
 rtl/inta_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_inta_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer for an 8259-style PIC in 8086 mode.
// Tracks the two INTA pulses, freezes the winning level, steers cascade and drives the vector byte.
module inta_sequencer #(
  parameter int GAP_TIMEOUT = 255,
  parameter int TIMER_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inta_n,
  input  logic       int_req,
  input  logic [2:0] highest_level,
  input  logic       spen,
  input  logic [7:0] slave_map,
  input  logic       ack,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  output logic       intr,
  output logic       cas_en,
  output logic [2:0] cas_sel,
  output logic       latch_isr,
  output logic [2:0] latched_level,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       eoi_auto
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ACK1 = 3'd2,
    GAP  = 3'd3,
    ACK2 = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic                 hist;
  logic [TIMER_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic                 spurious, spurious_nxt;
  logic                 is_master, is_master_nxt;
  logic                 intr_nxt;
  logic                 cas_en_nxt;
  logic [2:0]           cas_sel_nxt;
  logic                 latch_isr_nxt;
  logic [2:0]           latched_level_nxt;
  logic [7:0]           data_out_nxt;
  logic                 data_oe_nxt;
  logic                 eoi_auto_nxt;

  logic                 fall, rise;
  logic [2:0]           first_level;
  logic                 first_spurious;
  logic                 drive_vector;
  logic [TIMER_W-1:0]   gap_inc;

  assign fall = hist & ~inta_n;
  assign rise = ~hist & inta_n;

  // A request that vanished by the first fall is answered as spurious IR7.
  assign first_spurious = ~int_req;
  assign first_level    = int_req ? highest_level : 3'd7;

  // The vector comes from us unless a slave owns this level, or we are an unaddressed slave.
  assign drive_vector = is_master ? ~cas_en : ack;

  assign gap_inc = gap_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hist          <= 1'b1;
      gap_cnt       <= '0;
      spurious      <= 1'b0;
      is_master     <= 1'b0;
      intr          <= 1'b0;
      cas_en        <= 1'b0;
      cas_sel       <= 3'd0;
      latch_isr     <= 1'b0;
      latched_level <= 3'd0;
      data_out      <= 8'd0;
      data_oe       <= 1'b0;
      eoi_auto      <= 1'b0;
    end else begin
      state         <= state_nxt;
      hist          <= inta_n;
      gap_cnt       <= gap_cnt_nxt;
      spurious      <= spurious_nxt;
      is_master     <= is_master_nxt;
      intr          <= intr_nxt;
      cas_en        <= cas_en_nxt;
      cas_sel       <= cas_sel_nxt;
      latch_isr     <= latch_isr_nxt;
      latched_level <= latched_level_nxt;
      data_out      <= data_out_nxt;
      data_oe       <= data_oe_nxt;
      eoi_auto      <= eoi_auto_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    gap_cnt_nxt       = gap_cnt;
    spurious_nxt      = spurious;
    is_master_nxt     = is_master;
    intr_nxt          = intr;
    cas_en_nxt        = cas_en;
    cas_sel_nxt       = cas_sel;
    latch_isr_nxt     = 1'b0;
    latched_level_nxt = latched_level;
    data_out_nxt      = data_out;
    data_oe_nxt       = data_oe;
    eoi_auto_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        if (int_req) begin
          state_nxt = REQ;
          intr_nxt  = 1'b1;
        end
      end

      REQ: begin
        if (fall) begin
          state_nxt         = ACK1;
          intr_nxt          = 1'b0;
          is_master_nxt     = spen;
          spurious_nxt      = first_spurious;
          latched_level_nxt = first_level;
          latch_isr_nxt     = ~first_spurious;
          data_oe_nxt       = 1'b0;
          data_out_nxt      = 8'd0;
          if (spen && !first_spurious && slave_map[first_level]) begin
            cas_en_nxt  = 1'b1;
            cas_sel_nxt = first_level;
          end else begin
            cas_en_nxt  = 1'b0;
            cas_sel_nxt = 3'd0;
          end
        end else if (!int_req) begin
          state_nxt = IDLE;
          intr_nxt  = 1'b0;
        end
      end

      ACK1: begin
        data_oe_nxt = 1'b0;
        if (rise) begin
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
        end
      end

      GAP: begin
        gap_cnt_nxt = gap_inc;
        if (fall) begin
          state_nxt = ACK2;
          if (drive_vector) begin
            data_oe_nxt  = 1'b1;
            data_out_nxt = {vector_base, latched_level};
          end
        end else if (gap_inc == TIMER_W'(GAP_TIMEOUT)) begin
          // CPU never produced the second pulse: abandon the cycle quietly.
          state_nxt    = IDLE;
          cas_en_nxt   = 1'b0;
          cas_sel_nxt  = 3'd0;
          spurious_nxt = 1'b0;
        end
      end

      ACK2: begin
        if (rise) begin
          state_nxt    = IDLE;
          data_oe_nxt  = 1'b0;
          data_out_nxt = 8'd0;
          cas_en_nxt   = 1'b0;
          cas_sel_nxt  = 3'd0;
          eoi_auto_nxt = aeoi & ~spurious;
          spurious_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: drives INTA pulse pairs and checks each
// output against hand-computed values.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       inta_n;
  logic       int_req;
  logic [2:0] highest_level;
  logic       spen;
  logic [7:0] slave_map;
  logic       ack;
  logic [4:0] vector_base;
  logic       aeoi;
  logic       intr;
  logic       cas_en;
  logic [2:0] cas_sel;
  logic       latch_isr;
  logic [2:0] latched_level;
  logic [7:0] data_out;
  logic       data_oe;
  logic       eoi_auto;

  int tests_run = 0;
  int tests_failed = 0;

  inta_sequencer #(.GAP_TIMEOUT(255), .TIMER_W(8)) dut (
    .clk(clk), .rst(rst), .inta_n(inta_n), .int_req(int_req),
    .highest_level(highest_level), .spen(spen), .slave_map(slave_map),
    .ack(ack), .vector_base(vector_base), .aeoi(aeoi),
    .intr(intr), .cas_en(cas_en), .cas_sel(cas_sel), .latch_isr(latch_isr),
    .latched_level(latched_level), .data_out(data_out), .data_oe(data_oe),
    .eoi_auto(eoi_auto)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full two-pulse acknowledge. The caller sets spen/slave_map/ack/vector_base/aeoi.
  task automatic ack_cycle(input string name, input logic [2:0] lvl, input logic drop_at_fall,
                           input logic exp_latch, input logic [2:0] exp_lvl,
                           input logic exp_cas, input logic [2:0] exp_sel,
                           input logic exp_oe, input logic [7:0] exp_data, input logic exp_eoi);
    highest_level = lvl;
    int_req = 1'b1;
    inta_n  = 1'b1;
    step(1);
    check({name, ".int_up"}, intr, 1);
    inta_n = 1'b0;
    if (drop_at_fall) int_req = 1'b0;
    step(1);
    check({name, ".int_down"}, intr, 0);
    check({name, ".latch_isr"}, latch_isr, exp_latch);
    check({name, ".level"}, latched_level, exp_lvl);
    check({name, ".cas_en1"}, cas_en, exp_cas);
    check({name, ".cas_sel1"}, cas_sel, exp_sel);
    check({name, ".oe1"}, data_oe, 0);
    int_req = 1'b0;
    highest_level = 3'd6;
    step(1);
    check({name, ".latch_once"}, latch_isr, 0);
    inta_n = 1'b1;
    step(3);
    check({name, ".oe_gap"}, data_oe, 0);
    inta_n = 1'b0;
    step(1);
    check({name, ".oe2"}, data_oe, exp_oe);
    check({name, ".data2"}, data_out, exp_data);
    check({name, ".cas_en2"}, cas_en, exp_cas);
    check({name, ".cas_sel2"}, cas_sel, exp_sel);
    check({name, ".level_hold"}, latched_level, exp_lvl);
    inta_n = 1'b1;
    step(1);
    check({name, ".oe_end"}, data_oe, 0);
    check({name, ".data_end"}, data_out, 0);
    check({name, ".cas_end"}, cas_en, 0);
    check({name, ".eoi"}, eoi_auto, exp_eoi);
    step(1);
    check({name, ".eoi_once"}, eoi_auto, 0);
    check({name, ".int_idle"}, intr, 0);
  endtask

  initial begin
    rst = 1'b1;
    inta_n = 1'b1; int_req = 1'b0; highest_level = 3'd0; spen = 1'b1;
    slave_map = 8'h00; ack = 1'b0; vector_base = 5'h00; aeoi = 1'b0;
    step(2);
    check("rst.intr", intr, 0);
    check("rst.cas_en", cas_en, 0);
    check("rst.data_oe", data_oe, 0);
    check("rst.data_out", data_out, 0);
    check("rst.level", latched_level, 0);
    check("rst.latch", latch_isr, 0);
    rst = 1'b0;
    step(2);
    check("idle.intr", intr, 0);

    // Plain master, no slaves, level 3 -> vector 8'h43.
    spen = 1'b1; slave_map = 8'h00; vector_base = 5'h08; aeoi = 1'b0;
    ack_cycle("master", 3'd3, 1'b0, 1, 3'd3, 0, 3'd0, 1, 8'h43, 0);

    // Master with a slave on IR2: cascade steered, master stays off the bus.
    slave_map = 8'h04;
    ack_cycle("cascade", 3'd2, 1'b0, 1, 3'd2, 1, 3'd2, 0, 8'h00, 0);

    // Slave addressed by its master.
    spen = 1'b0; slave_map = 8'h00; ack = 1'b1; vector_base = 5'h10;
    ack_cycle("slave_ack", 3'd5, 1'b0, 1, 3'd5, 0, 3'd0, 1, 8'h85, 0);

    // Slave not addressed: silent.
    ack = 1'b0;
    ack_cycle("slave_nack", 3'd5, 1'b0, 1, 3'd5, 0, 3'd0, 0, 8'h00, 0);

    // Request vanishes with the first fall: spurious IR7, no ISR set, no auto EOI.
    spen = 1'b1; vector_base = 5'h08; aeoi = 1'b1;
    ack_cycle("spurious", 3'd4, 1'b1, 0, 3'd7, 0, 3'd0, 1, 8'h47, 0);

    // Automatic EOI on a normal sequence.
    vector_base = 5'h1F;
    ack_cycle("aeoi", 3'd1, 1'b0, 1, 3'd1, 0, 3'd0, 1, 8'hF9, 1);
    aeoi = 1'b0;

    // Request withdrawn before any INTA: back to idle.
    int_req = 1'b1;
    step(1);
    check("withdraw.up", intr, 1);
    int_req = 1'b0;
    step(1);
    check("withdraw.down", intr, 0);

    // Second pulse never arrives: abort after 255 gap cycles.
    slave_map = 8'h04; highest_level = 3'd2; int_req = 1'b1;
    step(1);
    inta_n = 1'b0;
    step(1);
    check("timeout.cas_on", cas_en, 1);
    int_req = 1'b0;
    inta_n = 1'b1;
    step(1);
    step(254);
    check("timeout.before", cas_en, 1);
    step(1);
    check("timeout.cas_off", cas_en, 0);
    check("timeout.sel_off", cas_sel, 0);
    inta_n = 1'b0;
    step(1);
    check("timeout.late_fall", data_oe, 0);
    inta_n = 1'b1;
    step(2);

    // Reset in the middle of the second pulse clears everything immediately.
    slave_map = 8'h00; vector_base = 5'h08; highest_level = 3'd3; int_req = 1'b1;
    step(1);
    inta_n = 1'b0;
    step(1);
    int_req = 1'b0;
    inta_n = 1'b1;
    step(2);
    inta_n = 1'b0;
    step(1);
    check("midrst.oe_before", data_oe, 1);
    rst = 1'b1;
    #1;
    check("midrst.oe", data_oe, 0);
    check("midrst.data", data_out, 0);
    check("midrst.cas", cas_en, 0);
    check("midrst.level", latched_level, 0);
    check("midrst.intr", intr, 0);
    inta_n = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
    check("midrst.idle_oe", data_oe, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
